// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad encoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, default parameter values, and the key map
// indexed by {row, col} plus a lookup helper.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } keypad_state_t;

    localparam int SCAN_DIV_DEF        = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int REPEAT_CYCLES_DEF   = 64;

    // Nibble i holds the code for index i = {row, col}, i.e. row*4 + col.
    //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: E 0 F D
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/keypad_encoder_if.sv
// Key output bus from the keypad encoder to the calculator input parser.
// Latency: n/a (wires only).
// Backpressure: none; the consumer must take every key_valid strobe.
//
// key_code  : code of the last accepted key, held until the next accept
// key_valid : one-cycle strobe, key_code valid in the same cycle
// key_held  : high while the accepted key is still down
interface keypad_encoder_if;

    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (output key_code, key_valid, key_held);
    modport slave  (input  key_code, key_valid, key_held);

endinterface

// File: rtl/keypad_encoder_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, width-parameterised.
// Latency: 2 clk cycles from d to q.
// Backpressure: none.
//
// Ports: clk, rst (sync, active-high, loads RST_VAL), d (async in), q (synchronised out).
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner: column scan, press/release debounce, key code + strobe.
// Latency: press-to-strobe at most 2 + 4*SCAN_DIV + DEBOUNCE_CYCLES + 1 cycles.
// Backpressure: none; key_valid is a fire-and-forget one-cycle strobe.
//
// Ports: clk, rst (sync, active-high), row_n[3:0] (async, active-low rows),
//        col_n[3:0] (registered one-cold column drive), key (keypad_encoder_if.master).
// Build option: define KEYPAD_AUTOREPEAT_EN to re-strobe a held key
//               (first after 4*REPEAT_CYCLES, then every REPEAT_CYCLES).
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = SCAN_DIV_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       row_n,
    output logic [3:0]       col_n,
    keypad_encoder_if.master key
);

    if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("keypad_encoder: parameter below its minimum");
    end

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEBOUNCE_CYCLES);

    keypad_state_t    state, state_nxt;
    logic [3:0]       row_s;
    logic [1:0]       col, col_nxt, cap_row, low_row;
    logic [DIV_W-1:0] div;
    logic [DEB_W-1:0] cnt, cnt_inc;
    logic             any_low, cap_low, scan_hit;
    logic             accept, col_adv, held, rep_fire;
    logic [3:0]       key_code_q;
    logic             key_valid_q;

    sync_2ff #(.WIDTH(4), .RST_VAL(4'hF)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_n),
        .q   (row_s)
    );

    // Lowest-index active row wins when several keys share the column.
    always_comb begin
        low_row = 2'd3;
        if      (!row_s[0]) low_row = 2'd0;
        else if (!row_s[1]) low_row = 2'd1;
        else if (!row_s[2]) low_row = 2'd2;
    end

    assign any_low  = ~&row_s;
    assign cap_low  = ~row_s[cap_row];
    assign scan_hit = (state == SCAN) && (div == DIV_LAST);
    assign cnt_inc  = (cnt == DEB_DONE) ? cnt : cnt + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= SCAN;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            SCAN:     if (scan_hit && any_low) state_nxt = DEBOUNCE;
            DEBOUNCE: if (!cap_low)                  state_nxt = SCAN;
                      else if (cnt_inc == DEB_DONE)  state_nxt = PRESSED;
            PRESSED:  if (!cap_low) state_nxt = RELEASE;
            RELEASE:  if (!cap_low && cnt_inc == DEB_DONE) state_nxt = SCAN;
            default:  state_nxt = SCAN;
        endcase
    end

    // Output / control decode
    always_comb begin
        held    = (state == PRESSED) || (state == RELEASE);
        accept  = (state == DEBOUNCE) && (state_nxt == PRESSED);
        // Move on after an empty column, an aborted debounce, or a finished release.
        col_adv = (scan_hit && !any_low) || ((state != SCAN) && (state_nxt == SCAN));
        col_nxt = col_adv ? col + 2'd1 : col;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div         <= '0;
            cnt         <= '0;
            col         <= 2'd0;
            col_n       <= 4'b1110;
            cap_row     <= 2'd0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            div   <= (state == SCAN && div != DIV_LAST) ? div + 1'b1 : '0;
            col   <= col_nxt;
            col_n <= ~(4'b0001 << col_nxt);
            if (scan_hit && any_low) cap_row <= low_row;
            // DEBOUNCE counts consecutive lows, RELEASE consecutive highs.
            case (state)
                DEBOUNCE: cnt <= cap_low ? cnt_inc : '0;
                RELEASE:  cnt <= cap_low ? '0 : cnt_inc;
                default:  cnt <= '0;
            endcase
            if (accept) key_code_q <= key_lookup(cap_row, col);
            key_valid_q <= accept | rep_fire;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(4 * REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(4 * REPEAT_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_first;

    // The strobe register adds one cycle, so fire one count early.
    assign rep_fire = held && cap_low && (rep_cnt == (rep_first ? REP_FIRST : REP_NEXT));

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else begin
            if (accept)        rep_first <= 1'b1;
            else if (rep_fire) rep_first <= 1'b0;
            if (!held || !cap_low || rep_fire) rep_cnt <= '0;
            else if (rep_cnt != REP_FIRST)     rep_cnt <= rep_cnt + 1'b1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign key.key_code  = key_code_q;
    assign key.key_valid = key_valid_q;
    assign key.key_held  = held;

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder with a behavioural 4x4 key matrix.
// Latency: n/a.
// Backpressure: n/a.
module tb_keypad_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] keys = '0;   // bit row*4+col closed

    keypad_encoder_if kif();

    keypad_encoder #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (16),
        .REPEAT_CYCLES   (64)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .row_n (row_n),
        .col_n (col_n),
        .key   (kif)
    );

    always #5 clk = ~clk;

    // A closed key pulls its row low while its column is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++)
            row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
    end

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         strobe_cnt = 0;
    int         dbl_cnt = 0;
    int         stamp [64];
    logic [3:0] codes [64];
    logic       prev_vld = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (kif.key_valid === 1'b1) begin
            if (strobe_cnt < 64) begin
                stamp[strobe_cnt] = cyc;
                codes[strobe_cnt] = kif.key_code;
            end
            strobe_cnt++;
            if (prev_vld) dbl_cnt++;
        end
        prev_vld = (kif.key_valid === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_col(input logic [3:0] target, input string tag);
        for (int i = 0; i < 64 && col_n !== target; i++) @(negedge clk);
        check(tag, 32'(col_n), 32'(target));
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int press_cyc;
        logic [3:0] exp_col;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_col_n", 32'(col_n), 32'(4'b1110));
        check("rst_code", 32'(kif.key_code), 32'(4'h0));
        check("rst_valid", 32'(kif.key_valid), 32'(1'b0));
        check("rst_held", 32'(kif.key_held), 32'(1'b0));
        rst = 1'b0;

        // Idle column rotation, 4 cycles per column
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << (((k + 1) / 4) % 4));
            check("rotate_col_n", 32'(col_n), 32'(exp_col));
        end

        // Single press of 5 (r1,c1)
        b = strobe_cnt;
        press_cyc = cyc;
        keys = 16'h0020;
        repeat (200) @(negedge clk);
        check("single_count", 32'(strobe_cnt - b), 32'd1);
        check("single_code", 32'(codes[b]), 32'(4'h5));
        check("single_latency", 32'((stamp[b] - press_cyc) <= 36), 32'd1);
        check("single_held", 32'(kif.key_held), 32'(1'b1));
        keys = '0;
        repeat (18) @(negedge clk);
        check("release_held_last", 32'(kif.key_held), 32'(1'b1));
        @(negedge clk);
        check("release_held_drop", 32'(kif.key_held), 32'(1'b0));
        check("release_next_col", 32'(col_n), 32'(4'b1011));
        check("release_code_kept", 32'(kif.key_code), 32'(4'h5));
        repeat (10) @(negedge clk);

        // Bounce on 8 (r2,c1): toggle every 3 cycles for 30 cycles, then stable
        b = strobe_cnt;
        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
            repeat (3) @(negedge clk);
        end
        check("bounce_no_strobe", 32'(strobe_cnt - b), 32'd0);
        keys = 16'h0200;
        repeat (100) @(negedge clk);
        check("bounce_count", 32'(strobe_cnt - b), 32'd1);
        check("bounce_code", 32'(codes[b]), 32'(4'h8));
        keys = '0;
        repeat (40) @(negedge clk);

        // D (r3,c3) with a 5-cycle re-contact during release
        b = strobe_cnt;
        keys = 16'h8000;
        repeat (60) @(negedge clk);
        check("d_count", 32'(strobe_cnt - b), 32'd1);
        check("d_code", 32'(codes[b]), 32'(4'hD));
        keys = '0;
        repeat (6) @(negedge clk);
        keys = 16'h8000;
        repeat (5) @(negedge clk);
        check("d_glitch_held", 32'(kif.key_held), 32'(1'b1));
        keys = '0;
        repeat (40) @(negedge clk);
        check("d_no_second", 32'(strobe_cnt - b), 32'd1);
        check("d_held_clear", 32'(kif.key_held), 32'(1'b0));

        // 1 and 7 together in column 0: lowest row wins
        b = strobe_cnt;
        keys = 16'h0101;
        repeat (60) @(negedge clk);
        check("two_count", 32'(strobe_cnt - b), 32'd1);
        check("two_code", 32'(codes[b]), 32'(4'h1));
        keys = '0;
        repeat (40) @(negedge clk);

        // Reset 8 cycles into the debounce of A (r0,c3)
        wait_col(4'b1011, "wait_col2");
        keys = 16'h0008;
        wait_col(4'b0111, "wait_col3");
        b = strobe_cnt;
        repeat (11) @(negedge clk);
        check("a_in_debounce", 32'(col_n), 32'(4'b0111));
        rst = 1'b1;
        @(negedge clk);
        check("midrst_col_n", 32'(col_n), 32'(4'b1110));
        check("midrst_valid", 32'(kif.key_valid), 32'(1'b0));
        check("midrst_held", 32'(kif.key_held), 32'(1'b0));
        check("midrst_code", 32'(kif.key_code), 32'(4'h0));
        rst = 1'b0;
        repeat (18) @(negedge clk);
        check("midrst_no_strobe", 32'(strobe_cnt - b), 32'd0);
        repeat (60) @(negedge clk);
        check("a_count", 32'(strobe_cnt - b), 32'd1);
        check("a_code", 32'(codes[b]), 32'(4'hA));
        keys = '0;
        repeat (40) @(negedge clk);

        // Hold 3 (r0,c2) for 600 cycles
        b = strobe_cnt;
        keys = 16'h0004;
        repeat (600) @(negedge clk);
        keys = '0;
        repeat (40) @(negedge clk);
`ifdef KEYPAD_AUTOREPEAT_EN
        check("rep_count_min", 32'((strobe_cnt - b) >= 4), 32'd1);
        check("rep_gap_first", 32'(stamp[b+1] - stamp[b]), 32'd256);
        check("rep_gap_2", 32'(stamp[b+2] - stamp[b+1]), 32'd64);
        check("rep_gap_3", 32'(stamp[b+3] - stamp[b+2]), 32'd64);
        for (int i = 0; i < 4; i++)
            check("rep_code", 32'(codes[b+i]), 32'(4'h3));
`else
        check("hold_count", 32'(strobe_cnt - b), 32'd1);
        check("hold_code", 32'(codes[b]), 32'(4'h3));
`endif
        check("no_back_to_back", 32'(dbl_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
